// File: rtl/matrix_key_scanner.sv
// Column-strobed key matrix scanner with frame-level debounce and single-key reporting.
// Optional MULTI_KEY_DETECT_EN rejects multi-key frames and flags them on MULTI_KEY.
module matrix_key_scanner #(
   parameter  int N_COLS         = 5,
   parameter  int N_ROWS         = 7,
   parameter  int SETTLE_CYCLES  = 4,
   parameter  int DEBOUNCE_SCANS = 3,
   localparam int CW             = $clog2(N_COLS),
   localparam int RW             = $clog2(N_ROWS)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [N_ROWS-1:0]    ROW,
   output logic [N_COLS-1:0]    COL,
   output logic                 KEY_VALID,
   output logic [CW+RW-1:0]     KEY_CODE,
   output logic                 KEY_HELD,
   output logic                 KEY_RELEASE,
   output logic                 MULTI_KEY
);
   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {SEARCH, CONFIRM, HELD} state_e;

   logic [N_ROWS-1:0]              row_s1_q, row_s2_q;
   logic [SW-1:0]                  slot_q, slot_d;
   logic [CW-1:0]                  col_idx_q, col_idx_d;
   logic [N_COLS-1:0]              col_q, col_d;
   logic [N_COLS-1:0][N_ROWS-1:0]  frame_q, frame_d, frame_now;
   state_e                         state_q, state_d;
   logic [DW-1:0]                  cnt_q, cnt_d, rel_cnt_q, rel_cnt_d;
   logic [CW+RW-1:0]               cand_q, cand_d, code_q, code_d, first_code;
   logic                           valid_q, valid_d, held_q, held_d, release_q, release_d;
   logic                           slot_last, col_last, eval, any_set, held_seen, multi_rej, accept;
`ifdef MULTI_KEY_DETECT_EN
   logic                           multi_set, multi_q, multi_d;
`endif

   // Scan timing: the frame is evaluated on the same edge that samples the last column.
   always_comb begin
      slot_last = (slot_q == SW'(SETTLE_CYCLES - 1));
      col_last  = (col_idx_q == CW'(N_COLS - 1));
      eval      = slot_last && col_last;
      slot_d    = slot_last ? '0 : slot_q + SW'(1);
      col_idx_d = col_idx_q;
      col_d     = col_q;
      if (slot_last) begin
         col_idx_d = col_last ? '0 : col_idx_q + CW'(1);
         col_d     = {col_q[N_COLS-2:0], col_q[N_COLS-1]};
      end
      frame_now            = frame_q;
      frame_now[col_idx_q] = row_s2_q;
      frame_d              = frame_q;
      if (slot_last) frame_d = col_last ? '0 : frame_now;
   end

   // Frame classification; scan order gives lowest column, then lowest row, priority.
   always_comb begin
      any_set    = 1'b0;
      held_seen  = 1'b0;
      first_code = '0;
`ifdef MULTI_KEY_DETECT_EN
      multi_set  = 1'b0;
`endif
      for (int c = 0; c < N_COLS; c++) begin
         for (int r = 0; r < N_ROWS; r++) begin
            if (frame_now[c][r]) begin
`ifdef MULTI_KEY_DETECT_EN
               if (any_set) multi_set = 1'b1;
`endif
               if (!any_set) first_code = {CW'(c), RW'(r)};
               any_set = 1'b1;
               if (code_q == {CW'(c), RW'(r)}) held_seen = 1'b1;
            end
         end
      end
`ifdef MULTI_KEY_DETECT_EN
      multi_rej = multi_set;
`else
      multi_rej = 1'b0;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rel_cnt_d = rel_cnt_q;
      cand_d    = cand_q;
      code_d    = code_q;
      held_d    = held_q;
      valid_d   = 1'b0;
      release_d = 1'b0;
      accept    = 1'b0;
      if (eval) begin
         case (state_q)
            SEARCH: begin
               if (multi_rej) begin
                  cnt_d = '0;
               end else if (any_set) begin
                  cand_d = first_code;
                  cnt_d  = DW'(1);
                  if (DEBOUNCE_SCANS == 1) accept = 1'b1;
                  else state_d = CONFIRM;
               end
            end
            CONFIRM: begin
               if (multi_rej || !any_set) begin
                  state_d = SEARCH;
                  cnt_d   = '0;
               end else if (first_code == cand_q) begin
                  if (cnt_q + DW'(1) == DW'(DEBOUNCE_SCANS)) accept = 1'b1;
                  else cnt_d = cnt_q + DW'(1);
               end else begin
                  cand_d = first_code;
                  cnt_d  = DW'(1);
               end
            end
            HELD: begin
               if (held_seen) begin
                  rel_cnt_d = '0;
               end else if (rel_cnt_q + DW'(1) == DW'(DEBOUNCE_SCANS)) begin
                  release_d = 1'b1;
                  held_d    = 1'b0;
                  state_d   = SEARCH;
                  rel_cnt_d = '0;
                  cnt_d     = '0;
               end else begin
                  rel_cnt_d = rel_cnt_q + DW'(1);
               end
            end
            default: state_d = SEARCH;
         endcase
         if (accept) begin
            valid_d   = 1'b1;
            code_d    = first_code;
            held_d    = 1'b1;
            state_d   = HELD;
            cnt_d     = '0;
            rel_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         row_s1_q  <= '0;
         row_s2_q  <= '0;
         slot_q    <= '0;
         col_idx_q <= '0;
         col_q     <= N_COLS'(1);
         frame_q   <= '0;
         state_q   <= SEARCH;
         cnt_q     <= '0;
         rel_cnt_q <= '0;
         cand_q    <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
         release_q <= 1'b0;
      end else begin
         row_s1_q  <= ROW;
         row_s2_q  <= row_s1_q;
         slot_q    <= slot_d;
         col_idx_q <= col_idx_d;
         col_q     <= col_d;
         frame_q   <= frame_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rel_cnt_q <= rel_cnt_d;
         cand_q    <= cand_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         held_q    <= held_d;
         release_q <= release_d;
      end
   end

`ifdef MULTI_KEY_DETECT_EN
   // Flag reflects the most recent evaluated frame outside HELD.
   always_comb begin
      multi_d = multi_q;
      if (eval) multi_d = multi_set && (state_q != HELD);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) multi_q <= 1'b0;
      else        multi_q <= multi_d;
   end

   assign MULTI_KEY = multi_q;
`else
   assign MULTI_KEY = 1'b0;
`endif

   assign COL         = col_q;
   assign KEY_VALID   = valid_q;
   assign KEY_CODE    = code_q;
   assign KEY_HELD    = held_q;
   assign KEY_RELEASE = release_q;
endmodule

// File: tb/tb_matrix_key_scanner.sv
// Scoreboard bench for matrix_key_scanner: frame-level key model, event queue, decoupled monitor.
module tb_matrix_key_scanner;
   localparam int NC = 5, NR = 7, SET = 4, DEB = 3;
   localparam int FRAME = NC * SET, NK = NC * NR;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [NR-1:0] ROW;
   logic [NC-1:0] COL;
   logic          KEY_VALID, KEY_HELD, KEY_RELEASE, MULTI_KEY;
   logic [5:0]    KEY_CODE;

   matrix_key_scanner #(.N_COLS(NC), .N_ROWS(NR), .SETTLE_CYCLES(SET), .DEBOUNCE_SCANS(DEB)) dut (
      .CLK(CLK), .RST_N(RST_N), .ROW(ROW), .COL(COL), .KEY_VALID(KEY_VALID),
      .KEY_CODE(KEY_CODE), .KEY_HELD(KEY_HELD), .KEY_RELEASE(KEY_RELEASE), .MULTI_KEY(MULTI_KEY));

   always #5 CLK = ~CLK;

   // Physical matrix: a pressed switch connects the strobed column to its row line.
   logic [NK-1:0] press;
   always_comb begin
      ROW = '0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            if (COL[c] && press[c*NR+r]) ROW[r] = 1'b1;
   end

   int cyc;
   always @(posedge CLK or negedge RST_N)
      if (!RST_N) cyc <= 0;
      else        cyc <= cyc + 1;

   typedef struct {bit rel; logic [5:0] code; int cyc;} ev_t;
   ev_t expq[$];

   int  n_tests = 0, n_fail = 0;
   bit  m_held, exp_multi;
   int  m_held_idx, m_run_idx, m_run_len, m_rel_len, frame_no;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [5:0] code_of(input int idx);
      logic [2:0] c, r;
      c = 3'(idx / NR);
      r = 3'(idx % NR);
      return {c, r};
   endfunction

   task automatic model_reset();
      m_held = 0; m_run_len = 0; m_rel_len = 0; m_run_idx = 0; m_held_idx = 0;
      exp_multi = 0; frame_no = 0;
   endtask

   // Frame-level reference: a key is accepted after DEB identical single-key frames,
   // released after DEB frames without it.
   task automatic model_frame(input logic [NK-1:0] mask);
      int  ones, low;
      bit  reject;
      ev_t e;
      ones = $countones(mask);
      low  = -1;
      for (int i = NK - 1; i >= 0; i--) if (mask[i]) low = i;
`ifdef MULTI_KEY_DETECT_EN
      reject    = (ones > 1);
      exp_multi = (ones > 1) && !m_held;
`else
      reject    = 0;
      exp_multi = 0;
`endif
      e.cyc = (frame_no + 1) * FRAME;
      if (m_held) begin
         if (mask[m_held_idx]) m_rel_len = 0;
         else m_rel_len++;
         if (m_rel_len == DEB) begin
            e.rel = 1; e.code = code_of(m_held_idx); expq.push_back(e);
            m_held = 0; m_run_len = 0;
         end
      end else begin
         if (ones == 0 || reject) m_run_len = 0;
         else if (m_run_len > 0 && low == m_run_idx) m_run_len++;
         else begin m_run_idx = low; m_run_len = 1; end
         if (m_run_len == DEB) begin
            e.rel = 0; e.code = code_of(low); expq.push_back(e);
            m_held = 1; m_held_idx = low; m_rel_len = 0; m_run_len = 0;
         end
      end
   endtask

   // Entered just after a frame-evaluation edge (or reset release); leaves on the next one.
   task automatic run_frame(input logic [NK-1:0] mask);
      press = mask;
      model_frame(mask);
      for (int i = 1; i <= FRAME; i++) begin
         @(posedge CLK); @(negedge CLK);
         check("col_strobe", 32'(COL), 32'(1 << ((i / SET) % NC)));
      end
      check("key_held", 32'(KEY_HELD), 32'(m_held));
      check("multi_key", 32'(MULTI_KEY), 32'(exp_multi));
      frame_no++;
   endtask

   function automatic logic [NK-1:0] key(input int c, input int r);
      logic [NK-1:0] m;
      m = '0;
      m[c*NR+r] = 1'b1;
      return m;
   endfunction

   // Monitor: pops an expectation whenever the DUT reports an event.
   initial begin
      ev_t e;
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1 && (KEY_VALID || KEY_RELEASE)) begin
            check("valid_release_excl", 32'(KEY_VALID && KEY_RELEASE), 32'(0));
            if (expq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_event: valid=%0b release=%0b code=%0h at cyc %0d, none expected",
                        KEY_VALID, KEY_RELEASE, KEY_CODE, cyc);
            end else begin
               e = expq.pop_front();
               check("ev_kind_release", 32'(KEY_RELEASE), 32'(e.rel));
               check("ev_code", 32'(KEY_CODE), 32'(e.code));
               check("ev_cycle", 32'(cyc), 32'(e.cyc));
               check("ev_held", 32'(KEY_HELD), 32'(!e.rel));
            end
         end
      end
   end

   initial begin
      logic [NK-1:0] ka, kb, m;
      int len;
      press = '0;
      RST_N = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("rst_col", 32'(COL), 32'(1));
      check("rst_outs", 32'({KEY_VALID, KEY_HELD, KEY_RELEASE, MULTI_KEY, KEY_CODE}), 32'(0));
      RST_N = 1'b1;

      // Clean press of (3,2) from the first frame
      ka = key(3, 2);
      repeat (4) run_frame(ka);

      // Asynchronous reset mid-frame while a key is held
      repeat (7) @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_col", 32'(COL), 32'(1));
      check("midrst_outs", 32'({KEY_VALID, KEY_HELD, KEY_RELEASE, MULTI_KEY, KEY_CODE}), 32'(0));
      check("midrst_pending", 32'(expq.size()), 32'(0));
      expq.delete();
      press = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      model_reset();

      // Bounce then stable press, then release
      ka = key(2, 5);
      run_frame(ka); run_frame('0); run_frame(ka); run_frame('0);
      repeat (4) run_frame(ka);
      repeat (4) run_frame('0);

      // Two keys together: (1,4) and (3,0)
      m = key(1, 4) | key(3, 0);
      repeat (3) run_frame(m);
      repeat (4) run_frame('0);

      // Second key while held; accepted only after the first is released
      ka = key(0, 3);
      kb = key(4, 6);
      repeat (3) run_frame(ka);
      repeat (3) run_frame(ka | kb);
      repeat (7) run_frame(kb);
      repeat (4) run_frame('0);

      // Randomized single-key / empty segments
      for (int s = 0; s < 40; s++) begin
         m = '0;
         if ($urandom_range(0, 2) != 0) m[$urandom_range(0, NK - 1)] = 1'b1;
         len = $urandom_range(1, 5);
         repeat (len) run_frame(m);
      end
      repeat (4) run_frame('0);

      @(negedge CLK);
      check("queue_drained", 32'(expq.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
